dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port byte-addressed data memory between two requesters:
//  port 0 = CPU load/store path, port 1 = loader/debug master.
//  Round-robin grant, one access per cycle; registered responses with backpressure.
//  Sits between the requesters and data_mem; drives data_mem adr/write_data/write_enable.
// PARAMETERS
//  WIDTH     32  address and data width
//  MEM_SIZE  17  log2 of the memory size in bytes; a request is in range iff adr+3 < 2**MEM_SIZE
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  req_valid[i]   in   1      requester i (i=0,1) presents a request
//  req_ready[i]   out  1      request i accepted this cycle (valid & ready)
//  req_we[i]      in   1      1 = 32-bit little-endian write, 0 = read
//  req_adr[i]     in   WIDTH  byte address
//  req_wdata[i]   in   WIDTH  write data
//  rsp_valid[i]   out  1      response for requester i held valid
//  rsp_ready[i]   in   1      requester i consumes its response
//  rsp_rdata[i]   out  WIDTH  read data (0 for writes and errors)
//  rsp_err[i]     out  1      out-of-range access; no memory effect
//  mem_adr        out  WIDTH  to data_mem adr
//  mem_wdata      out  WIDTH  to data_mem write_data
//  mem_we         out  1      to data_mem write_enable
//  mem_rdata      in   WIDTH  from data_mem read_data (combinational)
// BEHAVIOUR
//  - Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_adr=0, mem_wdata=0.
//    The rr pointer resets to favour port 0. Any held response is dropped.
//  - Per-port response slot state (enum): EMPTY, FULL. A port is eligible iff req_valid=1 and its
//    slot is EMPTY, or its slot is FULL and rsp_ready=1 in the same cycle (pass-through refill).
//  - Grant: at most one eligible port per cycle. If both are eligible, grant the port not granted
//    last. The pointer updates only on an actual grant. req_ready=1 only for the granted port.
//    req_ready is combinational from req_valid, the slot state and the pointer.
//  - On a grant in cycle T, mem_* are driven combinationally in T.
//    mem_we = req_we & in_range. The write commits at posedge ending T.
//    Read data (pre-write value) is captured at that same edge into rsp_rdata.
//    rsp_valid rises in T+1, giving a read/write latency of 1 cycle.
//  - With no grant: mem_we=0; mem_adr and mem_wdata hold their last values (no X).
//  - Out of range: rsp_err=1, rsp_rdata=0, mem_we forced 0. The request is still accepted and
//    still responded to.
//  - rsp_valid stays high with stable data until rsp_ready=1. Slot goes FULL->EMPTY on
//    consumption, unless refilled in the same cycle.
//  - A port with a FULL, unconsumed slot is skipped. The other port may proceed
//    (no head-of-line blocking).
//  - rst asserted mid-access: the write in that cycle is suppressed (mem_we gated by ~rst).
// CONFIGURATION
//  DMEM_ARB_FIXED_PRIO_EN defined:  fixed priority, port 0 always wins a tie; no rr pointer.
//  Not defined (default):           round-robin as above.
// STRUCTURE
//  dmem_arb_pkg: slot_state_t enum {EMPTY, FULL}, port_idx_t (1 bit), NUM_PORTS=2,
//    in_range() function.
//  Sub-module rr_arbiter_2: combinational 2-way grant from eligible[1:0] and pointer.
//    Pointer register is inside dmem_arbiter. The fixed-priority variant is selected there.
// TESTING
//  1 Single read: p0 reads 0x100 holding 0xDEADBEEF -> rsp_valid[0] at T+1, rdata=0xDEADBEEF, err=0.
//  2 Write/read: p1 writes 0x11223344 @0x20, then reads 0x20 -> byte 0x20=0x44, rdata=0x11223344.
//  3 Contention: both valid 4 cycles, rsp_ready=1 -> grants 0,1,0,1;
//    with FIXED_PRIO_EN -> 0,0,0,0.
//  4 Backpressure: p0 rsp_ready=0 -> p0 not regranted, p1 served each cycle;
//    p0 rdata stable until consumed.
//  5 Range: p0 writes @0x1FFFE (MEM_SIZE=17) -> err=1, mem_we=0, memory unchanged.
//  6 Reset: rst during p1 write -> no write; rsp_valid=0 next cycle; next grant goes to p0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    typedef logic port_idx_t;

    // A 32-bit access touches adr..adr+3, so the last byte must still be inside memory.
    function automatic logic in_range(input logic [63:0] adr, input int mem_size);
        return (adr + 64'd3) < (64'd1 << mem_size);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: on a tie the port not granted last time wins.
module rr_arbiter_2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  port_idx_t  last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between CPU (port 0) and loader (port 1) with registered responses.
// Define DMEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 wins ties).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MEM_SIZE = 17
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req_valid,
    output logic [NUM_PORTS-1:0]              req_ready,
    input  logic [NUM_PORTS-1:0]              req_we,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]   req_adr,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]              rsp_valid,
    input  logic [NUM_PORTS-1:0]              rsp_ready,
    output logic [NUM_PORTS-1:0][WIDTH-1:0]   rsp_rdata,
    output logic [NUM_PORTS-1:0]              rsp_err,
    output logic [WIDTH-1:0]                  mem_adr,
    output logic [WIDTH-1:0]                  mem_wdata,
    output logic                              mem_we,
    input  logic [WIDTH-1:0]                  mem_rdata
);

    slot_state_t          slot [NUM_PORTS];
    logic [1:0]           eligible;
    logic [1:0]           grant;
    logic                 any_grant;
    port_idx_t            sel;
    logic                 sel_in_range;
    logic [WIDTH-1:0]     adr_q;
    logic [WIDTH-1:0]     wdata_q;

    // A full slot can be refilled in the same cycle its response is consumed.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i]  = req_valid[i] & ((slot[i] == EMPTY) | rsp_ready[i]);
            rsp_valid[i] = (slot[i] == FULL);
        end
    end

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign grant = eligible[0] ? 2'b01 : {eligible[1], 1'b0};
`else
    port_idx_t last_grant;

    rr_arbiter_2 u_rr (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Reset value 1 makes port 0 the favoured side of the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (any_grant) begin
            last_grant <= sel;
        end
    end
`endif

    assign req_ready    = grant & {2{~rst}};
    assign any_grant    = |req_ready;
    assign sel          = port_idx_t'(req_ready[1]);
    assign sel_in_range = in_range(64'(req_adr[sel]), MEM_SIZE);
    assign mem_we       = any_grant & req_we[sel] & sel_in_range;

    // Address and data bus hold their last granted values between accesses.
    always_comb begin
        mem_adr   = adr_q;
        mem_wdata = wdata_q;
        if (rst) begin
            mem_adr   = '0;
            mem_wdata = '0;
        end else if (any_grant) begin
            mem_adr   = req_adr[sel];
            mem_wdata = req_wdata[sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q   <= '0;
            wdata_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                slot[i]      <= EMPTY;
                rsp_rdata[i] <= '0;
                rsp_err[i]   <= 1'b0;
            end
        end else begin
            if (any_grant) begin
                adr_q   <= req_adr[sel];
                wdata_q <= req_wdata[sel];
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_ready[i]) begin
                    slot[i]      <= FULL;
                    rsp_err[i]   <= ~sel_in_range;
                    rsp_rdata[i] <= (sel_in_range && !req_we[i]) ? mem_rdata : '0;
                end else if (rsp_ready[i]) begin
                    slot[i] <= EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array data memory and a reference memory model.
module tb_dmem_arbiter;

    localparam int WIDTH     = 32;
    localparam int MEM_SIZE  = 17;
    localparam int MEM_BYTES = 1 << MEM_SIZE;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][WIDTH-1:0]  req_adr;
    logic [1:0][WIDTH-1:0]  req_wdata;
    logic [1:0]             rsp_valid;
    logic [1:0]             rsp_ready;
    logic [1:0][WIDTH-1:0]  rsp_rdata;
    logic [1:0]             rsp_err;
    logic [WIDTH-1:0]       mem_adr;
    logic [WIDTH-1:0]       mem_wdata;
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_rdata;

    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    rsp_t        exp_q   [2][$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_adr   = '0;
    logic [31:0] last_wdata = '0;

    dmem_arbiter #(.WIDTH(WIDTH), .MEM_SIZE(MEM_SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Combinational little-endian read port of the data memory.
    always_comb begin
        logic [16:0] ma;
        ma = mem_adr[16:0];
        mem_rdata = {mem[ma + 17'd3], mem[ma + 17'd2], mem[ma + 17'd1], mem[ma]};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic ref_in_range(input logic [31:0] a);
        return ({1'b0, a} + 33'd3) < 33'(MEM_BYTES);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [16:0] i;
        i = a[16:0];
        return {ref_mem[i + 17'd3], ref_mem[i + 17'd2], ref_mem[i + 17'd1], ref_mem[i]};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            mem[a[16:0] + 17'(b)]     = d[8*b +: 8];
            ref_mem[a[16:0] + 17'(b)] = d[8*b +: 8];
        end
    endtask

    // One clock cycle: drive, check at the falling edge, model the accepted request, then advance.
    task automatic applyStimulus(input logic rst_i, input logic [1:0] v, input logic [1:0] we,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic [1:0] rr, input logic [1:0] exp_ready);
        rsp_t        e;
        logic [31:0] adr_a [2];
        logic [31:0] dat_a [2];
        logic        exp_we;
        logic [31:0] exp_adr;
        logic [31:0] exp_wdata;
        logic        w_en;
        logic [31:0] w_a;
        logic [31:0] w_d;
        adr_a[0] = a0; adr_a[1] = a1;
        dat_a[0] = d0; dat_a[1] = d1;
        rst = rst_i; req_valid = v; req_we = we; rsp_ready = rr;
        req_adr[0] = a0; req_adr[1] = a1;
        req_wdata[0] = d0; req_wdata[1] = d1;
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("rsp_valid%0d", p), 32'(rsp_valid[p]), 32'(exp_q[p].size() != 0));
            if (exp_q[p].size() != 0) begin
                e = exp_q[p][0];
                checkOutput($sformatf("rsp_rdata%0d", p), rsp_rdata[p], e.rdata);
                checkOutput($sformatf("rsp_err%0d", p), 32'(rsp_err[p]), 32'(e.err));
                if (rr[p]) void'(exp_q[p].pop_front());
            end
        end
        exp_we    = 1'b0;
        exp_adr   = rst_i ? 32'h0 : last_adr;
        exp_wdata = rst_i ? 32'h0 : last_wdata;
        for (int p = 0; p < 2; p++) begin
            if (exp_ready[p]) begin
                e.err   = !ref_in_range(adr_a[p]);
                e.rdata = (!e.err && !we[p]) ? ref_read(adr_a[p]) : 32'h0;
                if (!e.err && we[p]) begin
                    exp_we = 1'b1;
                    for (int b = 0; b < 4; b++) ref_mem[adr_a[p][16:0] + 17'(b)] = dat_a[p][8*b +: 8];
                end
                exp_q[p].push_back(e);
                exp_adr    = adr_a[p];
                exp_wdata  = dat_a[p];
                last_adr   = adr_a[p];
                last_wdata = dat_a[p];
            end
        end
        checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
        checkOutput("mem_adr", mem_adr, exp_adr);
        checkOutput("mem_wdata", mem_wdata, exp_wdata);
        w_en = mem_we; w_a = mem_adr; w_d = mem_wdata;
        @(posedge clk);
        #1;
        if (w_en) begin
            for (int b = 0; b < 4; b++) mem[w_a[16:0] + 17'(b)] = w_d[8*b +: 8];
        end
        if (rst_i) begin
            exp_q[0].delete();
            exp_q[1].delete();
            last_adr   = '0;
            last_wdata = '0;
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        preload(32'h100, 32'hDEADBEEF);
        preload(32'h1FFFC, 32'h5AA5_1234);

        // Reset state
        applyStimulus(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 2'b00);
        checkOutput("reset_rdata0", rsp_rdata[0], 32'h0);
        checkOutput("reset_err1", 32'(rsp_err[1]), 32'h0);

        $display("[TB] single read");
        applyStimulus(1'b0, 2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 2'b11, 2'b01);
        idle();

        $display("[TB] write then read");
        applyStimulus(1'b0, 2'b10, 2'b10, 32'h0, 32'h0, 32'h20, 32'h11223344, 2'b11, 2'b10);
        applyStimulus(1'b0, 2'b10, 2'b00, 32'h0, 32'h0, 32'h20, 32'h0, 2'b11, 2'b10);
        idle();
        checkOutput("mem_byte_0x20", 32'(mem[32'h20]), 32'h44);

        $display("[TB] contention");
        for (int c = 0; c < 4; c++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            applyStimulus(1'b0, 2'b11, 2'b00, 32'h100, 32'h0, 32'h20, 32'h0, 2'b11, 2'b01);
`else
            applyStimulus(1'b0, 2'b11, 2'b00, 32'h100, 32'h0, 32'h20, 32'h0, 2'b11,
                          (c % 2 == 0) ? 2'b01 : 2'b10);
`endif
        end
        idle();

        $display("[TB] backpressure");
        applyStimulus(1'b0, 2'b11, 2'b00, 32'h100, 32'h0, 32'h20, 32'h0, 2'b10, 2'b01);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, 32'h104, 32'h0, 32'h20, 32'h0, 2'b10, 2'b10);
        end
        applyStimulus(1'b0, 2'b11, 2'b00, 32'h104, 32'h0, 32'h20, 32'h0, 2'b11, 2'b01);
        idle();

        $display("[TB] range");
        applyStimulus(1'b0, 2'b01, 2'b01, 32'h1FFFE, 32'hCAFEF00D, 32'h0, 32'h0, 2'b11, 2'b01);
        applyStimulus(1'b0, 2'b01, 2'b00, 32'h1FFFC, 32'h0, 32'h0, 32'h0, 2'b11, 2'b01);
        idle();
        checkOutput("mem_byte_0x1fffe", 32'(mem[32'h1FFFE]), 32'hA5);

        $display("[TB] reset mid-access");
        applyStimulus(1'b0, 2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 2'b11, 2'b01);
        applyStimulus(1'b1, 2'b10, 2'b10, 32'h0, 32'h0, 32'h40, 32'h99999999, 2'b10, 2'b00);
        applyStimulus(1'b0, 2'b11, 2'b00, 32'h100, 32'h0, 32'h20, 32'h0, 2'b11, 2'b01);
        idle();
        idle();
        checkOutput("mem_byte_0x40", 32'(mem[32'h40]), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
